// File: rtl/uart_tx_top.sv
// uart_tx_top
// Serial UART transmitter. Each accepted request sends one frame:
// a start bit (0), eight data bits LSB first, one parity bit and a stop bit (1).
// Every bit is held for CLKS_PER_BIT system clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (1..65535)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk       system clock, rising edge active
//   rst       asynchronous active-low reset
//   tx_start  send request, sampled only while idle
//   tx_data   byte to send, captured when tx_start is accepted
//   tx_out    registered serial line, idles high
//   busy      high while a frame is in progress
//   done      one-cycle pulse in the first idle cycle after a frame

module uart_tx_top #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [15:0] clk_cnt, clk_next;
  logic        parity_bit, parity_next;
  logic        tx_out_next, busy_next, done_next;
  logic        period_end;

  assign period_end = (clk_cnt == LAST_CLK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= bit_next;
      clk_cnt    <= clk_next;
      parity_bit <= parity_next;
      tx_out     <= tx_out_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    bit_next    = bit_cnt;
    clk_next    = clk_cnt;
    parity_next = parity_bit;
    done_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (tx_start) begin
          state_next  = START;
          shift_next  = tx_data;
          parity_next = (^tx_data) ^ PARITY_ODD;
          bit_next    = '0;
          clk_next    = '0;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (period_end) begin
          clk_next = '0;
          case (state)
            START:  state_next = DATA;
            DATA: begin
              // Shift only at the end of a bit period so shift_reg[0] is the bit on the line.
              shift_next = {1'b0, shift_reg[7:1]};
              bit_next   = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state_next = PARITY;
              end
            end
            PARITY: state_next = STOP;
            default: begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          endcase
        end else begin
          clk_next = clk_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx_out itself is a
  // flop output and changes in the same cycle the state does.
  always_comb begin
    tx_out_next = 1'b1;
    busy_next   = (state_next != IDLE);
    case (state_next)
      IDLE:    tx_out_next = 1'b1;
      START:   tx_out_next = 1'b0;
      DATA:    tx_out_next = shift_next[0];
      PARITY:  tx_out_next = parity_next;
      STOP:    tx_out_next = 1'b1;
      default: tx_out_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Serial UART transmitter: accepts one 8-bit byte per request and drives a single framed bit stream: start bit, 8 data bits LSB first, one parity bit, one stop bit. It is the transmit end of the design's UART link and produces exactly the frame format the receive path checks for start, parity and stop errors. Bit timing comes from an internal clocks-per-bit counter, so the block needs only the system clock.

## Interface
- CLKS_PER_BIT, default 1: clock cycles each serial bit is held; legal range 1..65535.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_start  input  1  send request; sampled only while idle.
- tx_data  input  8  byte to send; captured in the cycle tx_start is accepted.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after a frame completes.

## Operation
- States:
  - IDLE: tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0].
  - PARITY: tx_out=parity bit.
  - STOP: tx_out=1.
- IDLE -> START: on a rising edge where tx_start=1.
  - tx_data is copied into shift_reg.
  - parity = ^tx_data ^ PARITY_ODD.
  - bit_cnt and clk_cnt are cleared.
- Each non-IDLE state holds for CLKS_PER_BIT cycles. clk_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 when the state advances.
- START -> DATA -> PARITY -> STOP -> IDLE.
- DATA lasts 8 bit periods. At the end of each bit period shift_reg shifts right by one and bit_cnt increments (0..7). The state leaves DATA when bit_cnt=7 and the period ends.
- tx_start is ignored in every state except IDLE.
- tx_data changes after acceptance have no effect on the frame in flight.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
- done is registered. It is 1 during the single cycle that immediately follows the last STOP cycle, which is the first IDLE cycle.
- tx_out is a registered output with no glitches. It changes only on the rising edge of clk or on assertion of rst.
- Reset (rst=0) at any time, including mid-frame, immediately forces:
  - state=IDLE, tx_out=1, busy=0, done=0;
  - shift_reg, bit_cnt and clk_cnt cleared.
  The frame in progress is abandoned. After release, the first accepted tx_start begins a fresh frame.

## Timing
- Reset values: tx_out=1, busy=0, done=0.
- Request accepted at edge E0: tx_out=0 and busy=1 are visible after E0.
- Frame length: 11*CLKS_PER_BIT cycles from E0 to the edge that enters IDLE. Breakdown: start 1, data 8, parity 1, stop 1 bit periods.
- Data bit k (k=0..7) is on tx_out during cycles E0+(1+k)*CLKS_PER_BIT through E0+(2+k)*CLKS_PER_BIT-1.
- done is high in cycle E0+11*CLKS_PER_BIT, and busy=0 in the same cycle.
- Back-to-back frames: if tx_start=1 in the done cycle, the next start bit begins on the following edge. The minimum gap between frames is therefore one extra idle (1) cycle beyond the stop bit.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then 0xA5 with CLKS_PER_BIT=1, PARITY_ODD=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 on consecutive cycles after acceptance. busy is high for exactly 11 cycles, then done pulses for 1 cycle.
- 0xA5 with PARITY_ODD=1 -> same sequence except the parity bit is 1. 0xFF with even parity -> parity 0. 0x01 with even parity -> parity 1.
- CLKS_PER_BIT=4, byte 0x3C:
  - each bit is held for exactly 4 cycles;
  - the frame spans 44 cycles;
  - done arrives at cycle 44 after acceptance.
- Pulse tx_start with 0x55 in the 5th frame cycle of an 0x0F frame, and change tx_data mid-frame -> the 0x0F frame completes unaltered. No second frame starts.
- Hold tx_start=1 continuously with tx_data=0x81 -> frames repeat every 12 cycles (CLKS_PER_BIT=1), with exactly one idle 1 between each stop bit and the next start bit.
- Assert rst during data bit 3 -> tx_out=1, busy=0 and done=0 asynchronously. After release, 0xC3 sent with even parity produces a correct full frame: 0,1,1,0,0,0,0,1,1,0,1.
